// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neural-net classification path.
//   DEF_NUM_CLASSES : default number of class scores produced by neural_net
//   DEF_SCORE_W     : default width of one signed class score
//   score_t         : signed score at the default width
//   argmax_state_t  : control states of class_argmax
// ---------------------------------------------------------------------------
package nn_pkg;

  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_SCORE_W     = 8;

  typedef logic signed [DEF_SCORE_W-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/argmax_update.sv
// ---------------------------------------------------------------------------
// argmax_update
// One step of the running best / runner-up search (purely combinational).
//   cand_score, cand_idx      : score and index of the class being examined
//   best_score, best_idx      : current leader
//   second_score              : current runner-up score
//   nxt_best_score/idx        : leader after considering the candidate
//   nxt_second_score          : runner-up after considering the candidate
// A candidate equal to the leader never displaces it, so the lowest index
// wins a tie and the tied score becomes the runner-up.
// ---------------------------------------------------------------------------
module argmax_update #(
  parameter int SCORE_W = 8,
  parameter int IDX_W   = 4
) (
  input  logic signed [SCORE_W-1:0] cand_score,
  input  logic        [IDX_W-1:0]   cand_idx,
  input  logic signed [SCORE_W-1:0] best_score,
  input  logic        [IDX_W-1:0]   best_idx,
  input  logic signed [SCORE_W-1:0] second_score,
  output logic signed [SCORE_W-1:0] nxt_best_score,
  output logic        [IDX_W-1:0]   nxt_best_idx,
  output logic signed [SCORE_W-1:0] nxt_second_score
);

  always_comb begin
    nxt_best_score   = best_score;
    nxt_best_idx     = best_idx;
    nxt_second_score = second_score;
    if (cand_score > best_score) begin
      nxt_second_score = best_score;
      nxt_best_score   = cand_score;
      nxt_best_idx     = cand_idx;
    end else if (cand_score > second_score) begin
      nxt_second_score = cand_score;
    end
  end

endmodule

// File: rtl/class_argmax.sv
// ---------------------------------------------------------------------------
// class_argmax
// Captures one score vector from neural_net, scans it one class per clock and
// reports the winning class, its score and the margin over the runner-up.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake; in_ready is high only in IDLE
//   scores               : NUM_CLASSES signed scores, sampled on acceptance
//   out_valid / out_ready: output handshake; result held until accepted
//   out_class            : index of the highest score (lowest index on tie)
//   out_score            : signed winning score
//   out_margin           : unsigned winner minus runner-up, SCORE_W+1 bits
// ---------------------------------------------------------------------------
module class_argmax
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = nn_pkg::DEF_NUM_CLASSES,
  parameter int SCORE_W     = nn_pkg::DEF_SCORE_W,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [SCORE_W-1:0] scores [NUM_CLASSES],
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [IDX_W-1:0]   out_class,
  output logic signed [SCORE_W-1:0] out_score,
  output logic        [SCORE_W:0]   out_margin
);

  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic        [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

  // Difference of two signed scores computed one bit wider so that the
  // full range (max - min) cannot wrap; the winner is never below the
  // runner-up, so the result is read as unsigned.
  function automatic logic [SCORE_W:0] win_margin(
    input logic signed [SCORE_W-1:0] best,
    input logic signed [SCORE_W-1:0] second
  );
    logic signed [SCORE_W:0] diff;
    diff = $signed({best[SCORE_W-1], best}) - $signed({second[SCORE_W-1], second});
    return $unsigned(diff);
  endfunction

  argmax_state_t              state_q,     state_d;
  logic        [IDX_W-1:0]    idx_q,       idx_d;
  logic signed [SCORE_W-1:0]  buf_q [NUM_CLASSES];
  logic signed [SCORE_W-1:0]  buf_d [NUM_CLASSES];
  logic signed [SCORE_W-1:0]  best_q,      best_d;
  logic        [IDX_W-1:0]    best_idx_q,  best_idx_d;
  logic signed [SCORE_W-1:0]  second_q,    second_d;
  logic                       out_valid_q, out_valid_d;
  logic        [IDX_W-1:0]    out_class_q, out_class_d;
  logic signed [SCORE_W-1:0]  out_score_q, out_score_d;
  logic        [SCORE_W:0]    out_margin_q, out_margin_d;

  logic signed [SCORE_W-1:0]  seed_best;
  logic        [IDX_W-1:0]    seed_best_idx;
  logic signed [SCORE_W-1:0]  seed_second;
  logic signed [SCORE_W-1:0]  upd_best;
  logic        [IDX_W-1:0]    upd_best_idx;
  logic signed [SCORE_W-1:0]  upd_second;

  // Seeding the search with (min, 0, min) at class 0 makes the first step
  // produce best=buf[0], best_idx=0, second=min for every buf[0] value,
  // including buf[0] == min.
  always_comb begin
    seed_best     = best_q;
    seed_best_idx = best_idx_q;
    seed_second   = second_q;
    if (idx_q == '0) begin
      seed_best     = SCORE_MIN;
      seed_best_idx = '0;
      seed_second   = SCORE_MIN;
    end
  end

  argmax_update #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IDX_W)
  ) u_update (
    .cand_score       (buf_q[idx_q]),
    .cand_idx         (idx_q),
    .best_score       (seed_best),
    .best_idx         (seed_best_idx),
    .second_score     (seed_second),
    .nxt_best_score   (upd_best),
    .nxt_best_idx     (upd_best_idx),
    .nxt_second_score (upd_second)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    second_d     = second_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
    out_margin_d = out_margin_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = scores;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        best_d     = upd_best;
        best_idx_d = upd_best_idx;
        second_d   = upd_second;
        idx_d      = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d        = '0;
          out_class_d  = upd_best_idx;
          out_score_d  = upd_best;
          out_margin_d = win_margin(upd_best, upd_second);
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        // Going back to IDLE (not straight to a new capture) keeps input
        // acceptance out of the output-handshake cycle.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) buf_q[i] <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      second_q     <= '0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_score_q  <= '0;
      out_margin_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      second_q     <= second_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
      out_margin_q <= out_margin_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_score  = out_score_q;
  assign out_margin = out_margin_q;

endmodule
